commit_unit: RTL

Retirement stage on the consumer side of the reorder buffer's head. Each cycle it takes the ROB head entry. Non-store results are written to the architectural register file. Stores run through a memory write handshake with data memory, and the unit returns a one-cycle store-done pulse so the ROB can retire the store. It sits between the ROB commit outputs and the register file / data memory write ports.

---
 rtl/commit_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/commit_unit.sv
// Retirement stage at the ROB head: commits register results and drives store writes to data memory.
// Latency: register path 1 cycle; stores take 3+ cycles (capture, request until ack or timeout, done pulse).
// Backpressure: register path always accepts; the store path holds the ROB head until store_read_out pulses.
module commit_unit #(
  parameter int ROB_SIZE = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [$clog2(ROB_SIZE)-1:0] rob_ix_in,
  input  logic [3:0]                  rob_itype_in,
  input  logic [31:0]                 rob_value_in,
  input  logic [31:0]                 rob_dest_in,
  input  logic                        rob_commit_in,
  input  logic                        rob_store_valid_in,
  output logic                        store_read_out,
  output logic                        rf_we_out,
  output logic [4:0]                  rf_addr_out,
  output logic [31:0]                 rf_data_out,
  output logic [$clog2(ROB_SIZE)-1:0] rf_rob_ix_out,
  output logic                        mem_req_out,
  output logic [31:0]                 mem_addr_out,
  output logic [31:0]                 mem_wdata_out,
  input  logic                        mem_ack_in,
  output logic                        err_out,
  output logic [31:0]                 commit_count_out,
  output logic [31:0]                 store_count_out
);

  localparam int IX_W = $clog2(ROB_SIZE);
  // Wide enough to hold the value TIMEOUT itself; never narrower than one bit.
  localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Store captured from the ROB head while the memory handshake runs.
  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [IX_W-1:0] ix;
  } store_t;

  state_t          state_q, state_d;
  store_t          st_q;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            capture;
  logic            set_err;
  logic            err_q;
  logic [31:0]     commit_count_q;
  logic [31:0]     store_count_q;

  // The instruction type is implied by which valid the ROB raises, and the
  // store tag is kept only so it is visible on the latched entry when debugging.
  logic unused_sig;
  assign unused_sig = ^{rob_itype_in, st_q.ix};

  // Store FSM next state, wait counter and handshake outputs.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    capture        = 1'b0;
    set_err        = 1'b0;
    mem_req_out    = 1'b0;
    store_read_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rob_store_valid_in) begin
          capture = 1'b1;
          wait_d  = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_req_out = 1'b1;
        // An ack arriving in the same cycle the counter expires still wins.
        if (mem_ack_in) begin
          state_d = DONE;
        end else if (wait_q == WC_W'(TIMEOUT)) begin
          // Drop the store but still retire it so the ROB cannot deadlock.
          set_err = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      DONE: begin
        store_read_out = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Store FSM state and wait counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Latch the store entry on capture; the memory bus is driven from this copy
  // so address and data stay stable for the whole request.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q <= '0;
    end else if (capture) begin
      st_q <= '{addr: rob_dest_in, data: rob_value_in, ix: rob_ix_in};
    end
  end

  assign mem_addr_out  = st_q.addr;
  assign mem_wdata_out = st_q.data;

  // Sticky store-timeout flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;

  // Register-file write port: one-cycle registered copy of the committing entry.
  // Writes to x0 are suppressed by dropping the enable only.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rf_we_out     <= 1'b0;
      rf_addr_out   <= '0;
      rf_data_out   <= '0;
      rf_rob_ix_out <= '0;
    end else begin
      rf_we_out <= rob_commit_in && (rob_dest_in[4:0] != 5'd0);
      if (rob_commit_in) begin
        rf_addr_out   <= rob_dest_in[4:0];
        rf_data_out   <= rob_value_in;
        rf_rob_ix_out <= rob_ix_in;
      end
    end
  end

  // Retirement counters; a register commit and a store retire in the same
  // cycle both count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_count_q <= '0;
      store_count_q  <= '0;
    end else begin
      commit_count_q <= commit_count_q + 32'(rob_commit_in) + 32'(store_read_out);
      store_count_q  <= store_count_q + 32'(store_read_out);
    end
  end

  assign commit_count_out = commit_count_q;
  assign store_count_out  = store_count_q;

endmodule
